// File: rtl/eyes_input_pkg.sv
// Shared types and default frame counts for the Eyes start/coin sequencer.
package eyes_input_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        START,
        COOL
    } seq_state_t;

    localparam int DEF_COIN_FRAMES  = 4;
    localparam int DEF_GAP_FRAMES   = 8;
    localparam int DEF_START_FRAMES = 4;
    localparam int DEF_COOL_FRAMES  = 8;
    localparam int DEF_CNT_W        = 6;

endpackage

// File: rtl/eyes_frame_tick.sv
// One-cycle frame tick on an ENA_6-qualified vblank rising edge.
module eyes_frame_tick (
    input  logic CLK,
    input  logic RESET,
    input  logic ENA_6,
    input  logic vblank,
    output logic tick
);

    logic vb_prev;
    logic primed;

    // The first sample after reset only primes the detector.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vb_prev <= 1'b0;
            primed  <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= ENA_6 & primed & vblank & ~vb_prev;
            if (ENA_6) begin
                vb_prev <= vblank;
                primed  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/eyes_credit_sequencer.sv
// Turns start requests into a timed coin-then-start sequence for the core.
module eyes_credit_sequencer
    import eyes_input_pkg::*;
#(
    parameter int COIN_FRAMES  = DEF_COIN_FRAMES,
    parameter int GAP_FRAMES   = DEF_GAP_FRAMES,
    parameter int START_FRAMES = DEF_START_FRAMES,
    parameter int COOL_FRAMES  = DEF_COOL_FRAMES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENA_6,
    input  logic vblank,
    input  logic req_start1,
    input  logic req_start2,
    output logic coin,
    output logic start1,
    output logic start2,
    output logic busy
);

    localparam int CMAX = (2 ** CNT_W) - 1;

    if (COIN_FRAMES < 1 || COIN_FRAMES > CMAX ||
        GAP_FRAMES < 1 || GAP_FRAMES > CMAX ||
        START_FRAMES < 1 || START_FRAMES > CMAX ||
        COOL_FRAMES < 1 || COOL_FRAMES > CMAX) begin : g_bad_param
        $error("frame count parameter out of range");
    end

    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_FRAMES - 1);

    logic tick;

    eyes_frame_tick u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENA_6  (ENA_6),
        .vblank (vblank),
        .tick   (tick)
    );

    seq_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic sel, sel_n, take;
    logic req1_q, req2_q, pend1, pend2;
    logic edge1, edge2;

    assign edge1 = req_start1 & ~req1_q;
    assign edge2 = req_start2 & ~req2_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (pend1 | pend2) begin
                    state_n = COIN;
                    sel_n   = ~pend1;
                    take    = 1'b1;
                end
            end
            COIN: if (tick) begin
                if (cnt == COIN_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            GAP: if (tick) begin
                if (cnt == GAP_LAST) begin
                    state_n = START;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            START: if (tick) begin
                if (cnt == START_LAST) begin
                    state_n = COOL;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            COOL: if (tick) begin
                if (cnt == COOL_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // A fresh edge on the player being served keeps its flag set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= 1'b0;
            req1_q <= 1'b0;
            req2_q <= 1'b0;
            pend1  <= 1'b0;
            pend2  <= 1'b0;
            coin   <= 1'b0;
            start1 <= 1'b0;
            start2 <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sel    <= sel_n;
            req1_q <= req_start1;
            req2_q <= req_start2;
            pend1  <= edge1 | (pend1 & ~(take & ~sel_n));
            pend2  <= edge2 | (pend2 & ~(take & sel_n));
            coin   <= (state == COIN);
            start1 <= (state == START) & ~sel;
            start2 <= (state == START) & sel;
            busy   <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_eyes_credit_sequencer.sv
// Bench for eyes_credit_sequencer: frame-level model plus directed scenarios.
module tb_eyes_credit_sequencer;

    localparam int C = 4;
    localparam int G = 8;
    localparam int S = 4;
    localparam int K = 8;
    localparam int TOTAL = C + G + S + K;
    localparam int FRAME = 16;

    logic CLK = 1'b0;
    logic RESET, ENA_6, vblank, req_start1, req_start2;
    logic coin, start1, start2, busy;

    eyes_credit_sequencer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENA_6      (ENA_6),
        .vblank     (vblank),
        .req_start1 (req_start1),
        .req_start2 (req_start2),
        .coin       (coin),
        .start1     (start1),
        .start2     (start2),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a sequence is "active" with t ticks elapsed since it began.
    logic m_active, m_pl, m_p1, m_p2, m_r1, m_r2;
    int   m_t;
    logic m_tick, m_vprev, m_primed;
    logic e_coin, e_s1, e_s2, e_busy;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_active <= 0; m_pl <= 0; m_p1 <= 0; m_p2 <= 0;
            m_r1 <= 0; m_r2 <= 0; m_t <= 0;
            m_tick <= 0; m_vprev <= 0; m_primed <= 0;
            e_coin <= 0; e_s1 <= 0; e_s2 <= 0; e_busy <= 0;
        end else begin
            automatic logic a = m_active;
            automatic int t = m_t;
            automatic logic pl = m_pl;
            automatic logic p1 = m_p1;
            automatic logic p2 = m_p2;
            automatic logic in_start = m_active && m_t >= C + G && m_t < C + G + S;
            e_coin <= m_active && m_t < C;
            e_s1   <= in_start && !m_pl;
            e_s2   <= in_start && m_pl;
            if (a) begin
                if (m_tick) begin
                    t = t + 1;
                    if (t == TOTAL) a = 0;
                end
            end else if (p1 || p2) begin
                a = 1;
                t = 0;
                pl = !p1;
                if (!pl) p1 = 0;
                else p2 = 0;
            end
            p1 = p1 | (req_start1 & !m_r1);
            p2 = p2 | (req_start2 & !m_r2);
            m_active <= a; m_t <= t; m_pl <= pl;
            m_p1 <= p1; m_p2 <= p2;
            m_r1 <= req_start1; m_r2 <= req_start2;
            e_busy <= a;
            m_tick <= ENA_6 && m_primed && vblank && !m_vprev;
            if (ENA_6) begin
                m_vprev  <= vblank;
                m_primed <= 1;
            end
        end
    end

    int ticks, coin_ticks, s1_ticks, s2_ticks, busy_ticks, quiet_ticks;
    int coin_rise, s1_rise, s2_rise, coin_cyc;
    int first_coin_tk, first_s2_tk;
    logic pc, p1o, p2o;

    task automatic clr();
        ticks = 0; coin_ticks = 0; s1_ticks = 0; s2_ticks = 0;
        busy_ticks = 0; quiet_ticks = 0; coin_rise = 0;
        s1_rise = 0; s2_rise = 0; coin_cyc = 0;
        first_coin_tk = -1; first_s2_tk = -1;
    endtask

    always @(negedge CLK) begin
        chk("coin", int'(coin), int'(e_coin));
        chk("start1", int'(start1), int'(e_s1));
        chk("start2", int'(start2), int'(e_s2));
        chk("busy", int'(busy), int'(e_busy));
        if (m_tick) begin
            ticks++;
            if (coin) coin_ticks++;
            if (start1) s1_ticks++;
            if (start2) s2_ticks++;
            if (busy) busy_ticks++;
            if (busy && !coin && !start1 && !start2) quiet_ticks++;
        end
        if (coin) coin_cyc++;
        if (coin && !pc) begin
            coin_rise++;
            if (first_coin_tk < 0) first_coin_tk = ticks;
        end
        if (start1 && !p1o) s1_rise++;
        if (start2 && !p2o) begin
            s2_rise++;
            if (first_s2_tk < 0) first_s2_tk = ticks;
        end
        pc = coin; p1o = start1; p2o = start2;
    end

    logic ena_on;
    int phase = 0;

    task automatic step();
        @(negedge CLK);
        ENA_6  = ena_on && phase[0];
        vblank = phase >= 12;
        phase  = (phase + 1) % FRAME;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n * FRAME; i++) step();
    endtask

    initial begin
        int reached;
        logic pre;
        RESET = 1; ENA_6 = 0; vblank = 0;
        req_start1 = 0; req_start2 = 0; ena_on = 1;
        pc = 0; p1o = 0; p2o = 0;
        clr();
        step(); step(); step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_coin", int'(coin), 0);
        RESET = 0;

        // 1: idle
        clr();
        frames(20);
        chk("t1_ticks", ticks, 20);
        chk("t1_coin_rise", coin_rise, 0);
        chk("t1_busy_ticks", busy_ticks, 0);

        // 2: single P1 sequence
        clr();
        req_start1 = 1;
        frames(1);
        req_start1 = 0;
        frames(35);
        chk("t2_coin_ticks", coin_ticks, 4);
        chk("t2_s1_ticks", s1_ticks, 4);
        chk("t2_s2_ticks", s2_ticks, 0);
        chk("t2_busy_ticks", busy_ticks, 24);
        chk("t2_quiet_ticks", quiet_ticks, 16);
        chk("t2_coin_rise", coin_rise, 1);

        // 3: simultaneous requests
        clr();
        req_start1 = 1; req_start2 = 1;
        frames(1);
        req_start1 = 0; req_start2 = 0;
        frames(60);
        chk("t3_coin_rise", coin_rise, 2);
        chk("t3_s1_rise", s1_rise, 1);
        chk("t3_s2_rise", s2_rise, 1);
        chk("t3_s2_delay", first_s2_tk - first_coin_tk, 36);

        // 4: held request
        clr();
        req_start2 = 1;
        frames(100);
        req_start2 = 0;
        frames(5);
        chk("t4_coin_rise", coin_rise, 1);
        chk("t4_s2_rise", s2_rise, 1);
        chk("t4_s1_rise", s1_rise, 0);

        // 5: reset during START
        req_start1 = 1; req_start2 = 1;
        frames(1);
        req_start1 = 0; req_start2 = 0;
        reached = 0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            step();
            if (m_active && m_t == C + G + 2) reached = 1;
        end
        chk("t5_reach", reached, 1);
        pre = start1;
        chk("t5_start1_pre", int'(pre), 1);
        RESET = 1;
        #1;
        chk("t5_async_coin", int'(coin), 0);
        chk("t5_async_start1", int'(start1), 0);
        chk("t5_async_busy", int'(busy), 0);
        step(); step(); step();
        RESET = 0;
        clr();
        frames(40);
        chk("t5_coin_rise", coin_rise, 0);
        chk("t5_busy_ticks", busy_ticks, 0);
        chk("t5_busy", int'(busy), 0);

        // 6: ENA_6 off freezes the sequence in COIN
        req_start1 = 1;
        frames(1);
        req_start1 = 0;
        ena_on = 0;
        clr();
        frames(10);
        chk("t6_ticks", ticks, 0);
        chk("t6_coin_cycles", coin_cyc, 10 * FRAME);
        chk("t6_busy", int'(busy), 1);
        ena_on = 1;
        frames(30);
        chk("t6_s1_rise", s1_rise, 1);
        chk("t6_busy_end", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
